// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-path widths, PC increment and fetch state encoding.
package cpu_pkg;
  localparam int ADDR_W = 64;
  localparam int INSTR_W = 32;
  localparam logic [ADDR_W-1:0] PC_INC = 64'd4;
  typedef enum logic {FETCH_WAIT = 1'b0, FETCH_VALID = 1'b1} fetch_state_t;
endpackage

// File: rtl/fetch_wait_counter.sv
// fetch_wait_counter: counts read-settle cycles and flags the capture cycle.
module fetch_wait_counter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);
  logic [3:0] cnt;
  assign tc = en && cnt == 4'(WAIT_CYCLES - 1);
  always_ff @(posedge clk)
    cnt <= (rst || clr || tc) ? '0 : en ? cnt + 4'd1 : cnt;
endmodule

// File: rtl/imem_fetch_sequencer.sv
// imem_fetch_sequencer: PC holder that paces imem reads and hands instructions to decode.
module imem_fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] START_PC = '0
) (
  input  logic               CLK,
  input  logic               Reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               misalign_err,
  output logic [31:0]        fetch_count
);
  fetch_state_t state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic tc, hs, capture;
  assign imem_addr = pc;
  assign hs = instr_valid && instr_ready;
  assign capture = tc && !redirect;
  fetch_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_cnt (
    .clk(CLK),
    .rst(Reset),
    .en(state == FETCH_WAIT),
    .clr(redirect),
    .tc(tc)
  );
  always_comb begin
    state_nxt = state;
    state_nxt = redirect ? FETCH_WAIT
              : state == FETCH_WAIT ? (tc ? FETCH_VALID : FETCH_WAIT)
              : (hs ? FETCH_WAIT : FETCH_VALID);
  end
  // a redirect on the capture cycle wins, so the stale read never reaches decode
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= FETCH_WAIT;
      pc <= START_PC;
      instr <= '0;
      instr_pc <= '0;
      instr_valid <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_nxt;
      misalign_err <= redirect && |redirect_pc[1:0];
      if (hs) fetch_count <= fetch_count + 32'd1;
      if (redirect) begin
        pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
        instr_valid <= 1'b0;
      end else if (capture) begin
        instr <= imem_data;
        instr_pc <= pc;
        instr_valid <= 1'b1;
        pc <= pc + PC_INC;
      end else if (hs) begin
        instr_valid <= 1'b0;
      end
    end
  end
endmodule
